// File: rtl/shot_pos_decoder.sv
// shot_pos_decoder
//   Receive side of the inter-board shot-position link. Pops bytes from a
//   first-word-fall-through UART RX FIFO and decodes 4-byte tagged frames
//   (payload = byte[7:3], tag = byte[2:0]) into a 10-bit x/y shot position.
//
//   Frame order / tags:  XL=001, XH=010, YL=101, YH=110
//   A byte is captured in the cycle the FIFO shows data and no pop is pending.
//   It is popped and decoded in the next cycle. Decoded results are registered.
//
// Ports
//   clk         system clock
//   rst         asynchronous reset, active low
//   en          decode enable; low = bytes still popped but discarded
//   rx_empty    FIFO empty flag
//   rx_data     FIFO head byte, valid while !rx_empty
//   rd_uart     FIFO pop strobe, one cycle per consumed byte
//   shot_xpos   last decoded x position
//   shot_ypos   last decoded y position
//   shot_valid  one-cycle pulse when shot_xpos/shot_ypos were updated
//   frame_err   one-cycle pulse on any dropped byte or partial frame
//   err_count   saturating count of frame_err pulses
module shot_pos_decoder #(
    parameter int unsigned TIMEOUT_CYCLES = 65_019_506
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       rx_empty,
    input  logic [7:0] rx_data,
    output logic       rd_uart,
    output logic [9:0] shot_xpos,
    output logic [9:0] shot_ypos,
    output logic       shot_valid,
    output logic       frame_err,
    output logic [7:0] err_count
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] TAG_XL = 3'b001;
    localparam logic [2:0] TAG_XH = 3'b010;
    localparam logic [2:0] TAG_YL = 3'b101;
    localparam logic [2:0] TAG_YH = 3'b110;

    typedef enum logic [1:0] {
        WAIT_XL,
        WAIT_XH,
        WAIT_YL,
        WAIT_YH
    } state_t;

    state_t           state_q,      state_d;
    logic [7:0]       byte_q,       byte_d;
    logic             rd_uart_q,    rd_uart_d;
    logic [4:0]       xl_q,         xl_d;
    logic [4:0]       xh_q,         xh_d;
    logic [4:0]       yl_q,         yl_d;
    logic [CNT_W-1:0] cnt_q,        cnt_d;
    logic [9:0]       shot_xpos_q,  shot_xpos_d;
    logic [9:0]       shot_ypos_q,  shot_ypos_d;
    logic             shot_valid_q, shot_valid_d;
    logic             frame_err_q,  frame_err_d;
    logic [7:0]       err_count_q,  err_count_d;

    logic       fetch;
    logic       timeout;
    logic       drop;
    logic [2:0] tag;
    logic [4:0] pay;

    // A byte is taken only when no pop is in flight, so the FIFO head has
    // always advanced before the next capture (at most one byte per 2 clk).
    assign fetch = !rx_empty && !rd_uart_q;
    assign tag   = byte_q[2:0];
    assign pay   = byte_q[7:3];

    // Byte activity in the same cycle wins over an expiring timeout.
    assign timeout = (state_q != WAIT_XL) && (cnt_q == CNT_LAST) && !fetch && !rd_uart_q;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d      = state_q;
        byte_d       = fetch ? rx_data : byte_q;
        rd_uart_d    = fetch;
        xl_d         = xl_q;
        xh_d         = xh_q;
        yl_d         = yl_q;
        shot_xpos_d  = shot_xpos_q;
        shot_ypos_d  = shot_ypos_q;
        shot_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        drop         = 1'b0;

        if (state_q == WAIT_XL || fetch || rd_uart_q || timeout) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (!en) begin
            // Disabled: bytes are consumed silently and any partial frame is forgotten.
            state_d = WAIT_XL;
            xl_d    = '0;
            xh_d    = '0;
            yl_d    = '0;
        end else if (rd_uart_q) begin
            unique case (tag)
                TAG_XL: begin
                    // XL always starts a fresh frame; mid-frame it also aborts the old one.
                    frame_err_d = (state_q != WAIT_XL);
                    xl_d        = pay;
                    xh_d        = '0;
                    yl_d        = '0;
                    state_d     = WAIT_XH;
                end
                TAG_XH: begin
                    if (state_q == WAIT_XH) begin
                        xh_d    = pay;
                        state_d = WAIT_YL;
                    end else begin
                        drop = 1'b1;
                    end
                end
                TAG_YL: begin
                    if (state_q == WAIT_YL) begin
                        yl_d    = pay;
                        state_d = WAIT_YH;
                    end else begin
                        drop = 1'b1;
                    end
                end
                TAG_YH: begin
                    if (state_q == WAIT_YH) begin
                        // Both coordinates update together so consumers never see a mixed pair.
                        shot_xpos_d  = {xh_q, xl_q};
                        shot_ypos_d  = {pay, yl_q};
                        shot_valid_d = 1'b1;
                        state_d      = WAIT_XL;
                        xl_d         = '0;
                        xh_d         = '0;
                        yl_d         = '0;
                    end else begin
                        drop = 1'b1;
                    end
                end
                default: drop = 1'b1;
            endcase
        end else if (timeout) begin
            drop = 1'b1;
        end

        if (drop) begin
            frame_err_d = 1'b1;
            state_d     = WAIT_XL;
            xl_d        = '0;
            xh_d        = '0;
            yl_d        = '0;
        end

        err_count_d = (frame_err_d && err_count_q != 8'hFF) ? err_count_q + 8'd1 : err_count_q;
    end

    // NOTE: all flops, including the captured byte, are reset so nothing stale survives rst.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= WAIT_XL;
            byte_q       <= '0;
            rd_uart_q    <= 1'b0;
            xl_q         <= '0;
            xh_q         <= '0;
            yl_q         <= '0;
            cnt_q        <= '0;
            shot_xpos_q  <= '0;
            shot_ypos_q  <= '0;
            shot_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            err_count_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q      <= state_d;
            byte_q       <= byte_d;
            rd_uart_q    <= rd_uart_d;
            xl_q         <= xl_d;
            xh_q         <= xh_d;
            yl_q         <= yl_d;
            cnt_q        <= cnt_d;
            shot_xpos_q  <= shot_xpos_d;
            shot_ypos_q  <= shot_ypos_d;
            shot_valid_q <= shot_valid_d;
            frame_err_q  <= frame_err_d;
            err_count_q  <= err_count_d;
        end
    end

    assign rd_uart    = rd_uart_q;
    assign shot_xpos  = shot_xpos_q;
    assign shot_ypos  = shot_ypos_q;
    assign shot_valid = shot_valid_q;
    assign frame_err  = frame_err_q;
    assign err_count  = err_count_q;

endmodule

// File: tb/tb_shot_pos_decoder.sv
// Testbench for shot_pos_decoder: FWFT FIFO model feeding the DUT, a
// frame-level reference model compared every cycle, and literal checks.
module tb_shot_pos_decoder;

    localparam int T = 100;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b1;
    logic       rx_empty;
    logic [7:0] rx_data;
    logic       rd_uart;
    logic [9:0] shot_xpos;
    logic [9:0] shot_ypos;
    logic       shot_valid;
    logic       frame_err;
    logic [7:0] err_count;

    // FIFO: written by the stimulus, popped on rd_uart.
    logic [7:0] mem [0:1023];
    int         wr_ptr = 0;
    int         rd_ptr = 0;

    assign rx_empty = (wr_ptr == rd_ptr);
    assign rx_data  = mem[rd_ptr];

    always #5 clk = ~clk;

    shot_pos_decoder #(.TIMEOUT_CYCLES(T)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .rx_empty  (rx_empty),
        .rx_data   (rx_data),
        .rd_uart   (rd_uart),
        .shot_xpos (shot_xpos),
        .shot_ypos (shot_ypos),
        .shot_valid(shot_valid),
        .frame_err (frame_err),
        .err_count (err_count)
    );

    always @(posedge clk) begin
        if (rd_uart) rd_ptr <= rd_ptr + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: frame position (0..3 = next expected XL/XH/YL/YH),
    // partial x/y as integers, cycle stamp of the last byte activity.
    int         exp_tag [4] = '{1, 2, 5, 6};
    logic       m_rd    = 1'b0;
    logic       m_valid = 1'b0;
    logic       m_err   = 1'b0;
    int         m_pos = 0, m_px = 0, m_py = 0, m_x = 0, m_y = 0, m_cnt = 0;
    int         cyc = 0, last = 0;
    logic       mf_fetch;
    logic [7:0] mb;
    int         tag, pay;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_rd = 1'b0; m_valid = 1'b0; m_err = 1'b0;
            m_pos = 0; m_px = 0; m_py = 0; m_x = 0; m_y = 0; m_cnt = 0;
            last = cyc;
        end else begin
            mf_fetch = (wr_ptr != rd_ptr) && !m_rd;
            m_valid  = 1'b0;
            m_err    = 1'b0;
            if (!en) begin
                m_pos = 0;
            end else if (m_rd) begin
                mb  = mem[rd_ptr];
                tag = int'(mb[2:0]);
                pay = int'(mb[7:3]);
                if (tag == 0 || tag == 3 || tag == 4 || tag == 7) begin
                    m_err = 1'b1;
                    m_pos = 0;
                end else if (tag == exp_tag[m_pos]) begin
                    case (m_pos)
                        0: m_px = pay;
                        1: m_px = m_px + pay * 32;
                        2: m_py = pay;
                        default: begin
                            m_x = m_px;
                            m_y = m_py + pay * 32;
                            m_valid = 1'b1;
                        end
                    endcase
                    m_pos = (m_pos + 1) % 4;
                end else begin
                    m_err = 1'b1;
                    if (tag == 1) begin
                        m_px  = pay;
                        m_pos = 1;
                    end else begin
                        m_pos = 0;
                    end
                end
            end else if (m_pos != 0 && cyc - last == T && !mf_fetch) begin
                m_err = 1'b1;
                m_pos = 0;
            end
            if (mf_fetch || m_rd) last = cyc;
            if (m_err && m_cnt < 255) m_cnt++;
            m_rd = mf_fetch;
            cyc++;
        end
    end

    // Per-cycle compare plus pulse monitors.
    logic prev_rd = 1'b0;
    int   n_valid = 0;
    int   n_pop   = 0;

    always @(negedge clk) begin
        if (rst) begin
            check("rd_uart",    int'(rd_uart),    int'(m_rd));
            check("shot_xpos",  int'(shot_xpos),  m_x);
            check("shot_ypos",  int'(shot_ypos),  m_y);
            check("shot_valid", int'(shot_valid), int'(m_valid));
            check("frame_err",  int'(frame_err),  int'(m_err));
            check("err_count",  int'(err_count),  m_cnt);
            check("rd_back_to_back", int'(rd_uart & prev_rd), 0);
            prev_rd = rd_uart;
            if (shot_valid) n_valid++;
            if (rd_uart)    n_pop++;
        end
    end

    task automatic push(input logic [7:0] b);
        mem[wr_ptr] = b;
        wr_ptr++;
    endtask

    // Returns at the first falling edge with the FIFO empty and no pop in flight.
    task automatic drain();
        int n = 0;
        while ((wr_ptr != rd_ptr || rd_uart) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("drain_bound", int'(n < 3000), 1);
    endtask

    task automatic settle();
        repeat (2) @(negedge clk);
    endtask

    int p0;

    initial begin
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_xpos",  int'(shot_xpos),  0);
        check("reset_ypos",  int'(shot_ypos),  0);
        check("reset_count", int'(err_count),  0);
        check("reset_rd",    int'(rd_uart),    0);
        rst = 1'b1;
        @(negedge clk);

        // 1: 0x29 -> XL=5, 0x0A -> XH=1, 0xC5 -> YL=24, 0x0E -> YH=1 : x=0x025, y=0x038
        push(8'h29); push(8'h0A); push(8'hC5); push(8'h0E);
        drain(); settle();
        check("t1_x",     int'(shot_xpos), 'h025);
        check("t1_y",     int'(shot_ypos), 'h038);
        check("t1_valid", n_valid, 1);

        // 2: XL, XH, XL again -> error, restart with new XL=5; then XH=2, YL=24, YH=0
        push(8'h29); push(8'h0A); push(8'h29);
        drain(); settle();
        check("t2_err", int'(err_count), 1);
        push(8'h12); push(8'hC5); push(8'h06);
        drain(); settle();
        check("t2_x",     int'(shot_xpos), 'h045);
        check("t2_y",     int'(shot_ypos), 'h018);
        check("t2_valid", n_valid, 2);

        // 3: undefined tag mid-frame, shot_* held; then x=0x3FF, y=0x3E0
        push(8'h29); push(8'h0A); push(8'h3F);
        drain(); settle();
        check("t3_err",  int'(err_count), 2);
        check("t3_hold", int'(shot_xpos), 'h045);
        push(8'hF9); push(8'hFA); push(8'h05); push(8'hFE);
        drain(); settle();
        check("t3_x", int'(shot_xpos), 'h3FF);
        check("t3_y", int'(shot_ypos), 'h3E0);

        // 4: partial frame then long idle -> timeout error
        push(8'h29); push(8'h0A);
        drain();
        repeat (110) @(negedge clk);
        check("t4_timeout", int'(err_count), 3);
        // 99 idle cycles between bytes: next byte lands on the last counted cycle
        push(8'h29); drain(); repeat (99) @(negedge clk);
        push(8'h0A); drain(); repeat (99) @(negedge clk);
        push(8'hC5); drain(); repeat (99) @(negedge clk);
        push(8'h0E); drain(); settle();
        check("t4_no_err", int'(err_count), 3);
        check("t4_x",      int'(shot_xpos), 'h025);
        check("t4_valid",  n_valid, 4);

        // 5: saturation, then async reset mid-frame
        for (int i = 0; i < 300; i++) push(8'h00);
        drain(); settle();
        check("t5_sat", int'(err_count), 'hFF);
        push(8'h29); push(8'h0A);
        drain();
        #2 rst = 1'b0;
        #1;
        check("t5_rst_x",     int'(shot_xpos),  0);
        check("t5_rst_y",     int'(shot_ypos),  0);
        check("t5_rst_cnt",   int'(err_count),  0);
        check("t5_rst_valid", int'(shot_valid), 0);
        check("t5_rst_err",   int'(frame_err),  0);
        @(negedge clk);
        rst = 1'b1;
        push(8'hC5); push(8'h0E);
        drain(); settle();
        check("t5_no_valid", n_valid, 4);
        check("t5_post_err", int'(err_count), 2);
        check("t5_post_x",   int'(shot_xpos), 0);

        // 6: disabled decode still pops, no strobes
        en = 1'b0;
        p0 = n_pop;
        push(8'h29); push(8'h0A); push(8'hC5); push(8'h0E);
        drain(); settle();
        check("t6_pops",  n_pop - p0, 4);
        check("t6_valid", n_valid, 4);
        check("t6_err",   int'(err_count), 2);
        en = 1'b1;
        push(8'h29); push(8'h0A); push(8'hC5); push(8'h0E);
        drain(); settle();
        check("t6_valid_on", n_valid, 5);
        check("t6_x", int'(shot_xpos), 'h025);
        check("t6_y", int'(shot_ypos), 'h038);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
